// File: rtl/mdu_hilo_producer_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Covers op codes, FSM state encodings, datapath width and a conditional-negate helper.
package mdu_hilo_producer_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic [MDU_XLEN-1:0] cond_negate(input logic [MDU_XLEN-1:0] value,
                                                      input logic neg);
    return neg ? -value : value;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// After WIDTH steps following a load, quotient and remainder are final.
module mdu_div_iter
  import mdu_hilo_producer_pkg::*;
#(
  parameter int WIDTH = MDU_XLEN
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // A set top bit of the trial difference means the partial remainder was below the divisor.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo_producer.sv
// EX-stage multiply/divide unit producing HI/LO for MULT/MULTU/DIV/DIVU with a pipeline stall.
// Define MDU_FAST_MUL_EN for a single-pass multiplier; otherwise multiply is shift-add over MUL_ITER cycles.
module mdu_hilo_producer
  import mdu_hilo_producer_pkg::*;
#(
  parameter int DIV_ITER = 32,
  parameter int MUL_ITER = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [MDU_XLEN-1:0] src_a,
  input  logic [MDU_XLEN-1:0] src_b,
  input  logic                flush,
  output logic                stall_req,
  output logic                ex_is_write_hi,
  output logic                ex_is_write_lo,
  output logic [MDU_XLEN-1:0] ex_write_hi_value,
  output logic [MDU_XLEN-1:0] ex_write_lo_value
);

  localparam int MAX_ITER = (DIV_ITER > MUL_ITER) ? DIV_ITER : MUL_ITER;
  localparam int CNT_W    = $clog2(MAX_ITER + 1);
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_CYCLES = 1;
`else
  localparam int MUL_CYCLES = MUL_ITER;
`endif

  mdu_state_e                state;
  mdu_op_e                   op_q;
  logic                      sign_a_q;
  logic                      sign_b_q;
  logic                      div_zero_q;
  logic [MDU_XLEN-1:0]       mag_a_q;
  logic [2*MDU_XLEN-1:0]     prod_q;
  logic [CNT_W-1:0]          count_q;
  logic [MDU_XLEN-1:0]       hi_q;
  logic [MDU_XLEN-1:0]       lo_q;

  logic                      launch;
  logic                      is_div_op;
  logic                      in_sign_a;
  logic                      in_sign_b;
  logic                      in_div_zero;
  logic [MDU_XLEN-1:0]       in_mag_a;
  logic [MDU_XLEN-1:0]       in_mag_b;
  logic                      div_load;
  logic                      div_step;
  logic [MDU_XLEN-1:0]       quotient;
  logic [MDU_XLEN-1:0]       remainder;
  logic [2*MDU_XLEN-1:0]     prod_final;
  logic [MDU_XLEN-1:0]       res_hi;
  logic [MDU_XLEN-1:0]       res_lo;

  assign launch      = (state == ST_IDLE) & start & ~flush;
  assign is_div_op   = op[1];
  assign in_sign_a   = ~op[0] & src_a[MDU_XLEN-1];
  assign in_sign_b   = ~op[0] & src_b[MDU_XLEN-1];
  assign in_div_zero = is_div_op & (src_b == '0);
  // A divide by zero never touches the multiplier, so mag_a_q carries the raw dividend for HI.
  assign in_mag_a    = in_div_zero ? src_a : cond_negate(src_a, in_sign_a);
  assign in_mag_b    = cond_negate(src_b, in_sign_b);

  assign div_load = launch & is_div_op & ~in_div_zero;
  assign div_step = (state == ST_DIV) & ~flush;

  mdu_div_iter #(.WIDTH(MDU_XLEN)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .load      (div_load),
    .step      (div_step),
    .dividend  (in_mag_a),
    .divisor   (in_mag_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

`ifndef MDU_FAST_MUL_EN
  logic [MDU_XLEN:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[2*MDU_XLEN-1:MDU_XLEN]}
                 + (prod_q[0] ? {1'b0, mag_a_q} : {(MDU_XLEN+1){1'b0}});
`endif

  // Sign flags are only ever set for MULT/DIV, so unsigned ops pass through untouched.
  assign prod_final = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;

  always_comb begin
    res_hi = prod_final[2*MDU_XLEN-1:MDU_XLEN];
    res_lo = prod_final[MDU_XLEN-1:0];
    if (op_q == MDU_DIV || op_q == MDU_DIVU) begin
      if (div_zero_q) begin
        res_hi = mag_a_q;
        res_lo = '1;
      end else begin
        res_lo = cond_negate(quotient, sign_a_q ^ sign_b_q);
        res_hi = cond_negate(remainder, sign_a_q);
      end
    end
  end

  // prod_q low half holds the multiplier magnitude until the multiply consumes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      op_q       <= MDU_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      mag_a_q    <= '0;
      prod_q     <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q       <= mdu_op_e'(op);
            sign_a_q   <= in_sign_a;
            sign_b_q   <= in_sign_b;
            div_zero_q <= in_div_zero;
            mag_a_q    <= in_mag_a;
            prod_q     <= {{MDU_XLEN{1'b0}}, in_mag_b};
            if (!is_div_op) begin
              state   <= ST_MUL;
              count_q <= CNT_W'(MUL_CYCLES);
            end else if (in_div_zero) begin
              state <= ST_DONE;
            end else begin
              state   <= ST_DIV;
              count_q <= CNT_W'(DIV_ITER);
            end
          end
        end
        ST_MUL: begin
`ifdef MDU_FAST_MUL_EN
          prod_q <= {{MDU_XLEN{1'b0}}, mag_a_q} * {{MDU_XLEN{1'b0}}, prod_q[MDU_XLEN-1:0]};
`else
          prod_q <= {mul_sum, prod_q[MDU_XLEN-1:1]};
`endif
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DIV: begin
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          hi_q  <= res_hi;
          lo_q  <= res_lo;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall_req = resetn & ~flush &
                     (((state == ST_IDLE) & start) | (state == ST_MUL) | (state == ST_DIV));
  assign ex_is_write_hi    = (state == ST_DONE) & ~flush;
  assign ex_is_write_lo    = (state == ST_DONE) & ~flush;
  assign ex_write_hi_value = (state == ST_DONE) ? res_hi : hi_q;
  assign ex_write_lo_value = (state == ST_DONE) ? res_lo : lo_q;

endmodule

// File: tb/tb_mdu_hilo_producer.sv
// Self-checking bench for mdu_hilo_producer: directed corner cases plus random ops against an arithmetic model.
// Latency expectations follow MDU_FAST_MUL_EN when it is defined.
module tb_mdu_hilo_producer;
  import mdu_hilo_producer_pkg::*;

  localparam int DIV_ITER = 32;
  localparam int MUL_ITER = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = MUL_ITER + 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic        ex_is_write_hi;
  logic        ex_is_write_lo;
  logic [31:0] ex_write_hi_value;
  logic [31:0] ex_write_lo_value;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  mdu_hilo_producer #(.DIV_ITER(DIV_ITER), .MUL_ITER(MUL_ITER)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .op                (op),
    .src_a             (src_a),
    .src_b             (src_b),
    .flush             (flush),
    .stall_req         (stall_req),
    .ex_is_write_hi    (ex_is_write_hi),
    .ex_is_write_lo    (ex_is_write_lo),
    .ex_write_hi_value (ex_write_hi_value),
    .ex_write_lo_value (ex_write_lo_value)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Arithmetic reference: HI/LO and the cycle index in which the result is presented.
  function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sa, sb, sq, sr;
    logic [63:0] p, ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = '0;
    lo = '0;
    lat = MUL_LAT;
    if (mop[1] == 1'b0) begin
      if (mop == MDU_MULT) p = sa * sb;
      else                 p = ua * ub;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      lat = DIV_ITER + 1;
      if (mop == MDU_DIV) begin
        sq = sa / sb;
        sr = sa % sb;
        hi = sr[31:0];
        lo = sq[31:0];
      end else begin
        uq = ua / ub;
        ur = ua % ub;
        hi = ur[31:0];
        lo = uq[31:0];
      end
    end
  endfunction

  // Caller sits on a falling edge; returns on the falling edge of the cycle after DONE with start still high.
  task automatic apply_stimulus(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                input string tag);
    logic [31:0] eh, el;
    int          lat;
    model(mop, a, b, eh, el, lat);
    start = 1'b1;
    op    = mop;
    src_a = a;
    src_b = b;
    for (int c = 0; c <= lat; c++) begin
      #1;
      check_output({tag, " stall"}, 32'(stall_req), 32'(c < lat));
      check_output({tag, " we"}, {30'd0, ex_is_write_hi, ex_is_write_lo}, (c == lat) ? 32'd3 : 32'd0);
      if (c == lat) begin
        check_output({tag, " hi"}, ex_write_hi_value, eh);
        check_output({tag, " lo"}, ex_write_lo_value, el);
      end
      @(negedge clk);
    end
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic idle_check(input int n, input string tag);
    start = 1'b0;
    for (int c = 0; c < n; c++) begin
      #1;
      check_output({tag, " idle stall"}, 32'(stall_req), 32'd0);
      check_output({tag, " idle we"}, {30'd0, ex_is_write_hi, ex_is_write_lo}, 32'd0);
      check_output({tag, " held hi"}, ex_write_hi_value, last_hi);
      check_output({tag, " held lo"}, ex_write_lo_value, last_lo);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, eh, el;
    logic [1:0]  rop;
    int          lat;

    repeat (2) @(negedge clk);
    #1;
    check_output("reset stall", 32'(stall_req), 32'd0);
    check_output("reset we", {30'd0, ex_is_write_hi, ex_is_write_lo}, 32'd0);
    check_output("reset hi", ex_write_hi_value, 32'd0);
    check_output("reset lo", ex_write_lo_value, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    apply_stimulus(MDU_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    idle_check(2, "after_mult");
    apply_stimulus(MDU_DIVU, 32'd100, 32'd7, "divu_100_7");
    idle_check(1, "after_divu");
    apply_stimulus(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    apply_stimulus(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    idle_check(1, "after_ovf");
    apply_stimulus(MDU_DIV, 32'd5, 32'd0, "div_5_0");
    apply_stimulus(MDU_DIVU, 32'hDEAD_BEEF, 32'd0, "divu_by_0");
    apply_stimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    apply_stimulus(MDU_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    idle_check(1, "after_mults");

    // Flush partway through a divide: no write pulse, held values untouched.
    start = 1'b1; op = MDU_DIVU; src_a = 32'd1000; src_b = 32'd3;
    for (int c = 0; c < 10; c++) begin
      #1;
      check_output("flush_pre stall", 32'(stall_req), 32'd1);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check_output("flush stall", 32'(stall_req), 32'd0);
    check_output("flush we", {30'd0, ex_is_write_hi, ex_is_write_lo}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    idle_check(DIV_ITER + 3, "post_flush");
    apply_stimulus(MDU_DIVU, 32'd1000, 32'd3, "divu_after_flush");
    idle_check(1, "after_reflush");

    // Flush landing on the DONE cycle suppresses the write.
    model(MDU_DIV, 32'd12345, 32'hFFFF_FFEF, eh, el, lat);
    start = 1'b1; op = MDU_DIV; src_a = 32'd12345; src_b = 32'hFFFF_FFEF;
    for (int c = 0; c < lat; c++) begin
      #1;
      check_output("flush_done pre stall", 32'(stall_req), 32'd1);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check_output("flush_done we", {30'd0, ex_is_write_hi, ex_is_write_lo}, 32'd0);
    check_output("flush_done stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    idle_check(2, "post_flush_done");

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      apply_stimulus(rop, ra, rb, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle_check(1, $sformatf("rand%0d", i));
    end

    // Reset in the middle of a divide clears everything at once.
    start = 1'b1; op = MDU_DIV; src_a = 32'h1234_5678; src_b = 32'd77;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_output("rst_mid stall", 32'(stall_req), 32'd0);
    check_output("rst_mid we", {30'd0, ex_is_write_hi, ex_is_write_lo}, 32'd0);
    check_output("rst_mid hi", ex_write_hi_value, 32'd0);
    check_output("rst_mid lo", ex_write_lo_value, 32'd0);
    @(negedge clk);
    start   = 1'b0;
    resetn  = 1'b1;
    last_hi = '0;
    last_lo = '0;
    idle_check(2, "post_reset");
    apply_stimulus(MDU_MULTU, 32'h0001_0000, 32'h0001_0003, "multu_after_reset");
    idle_check(2, "final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
